base_afirst: RTL and testbench

Lossy, order-preserving input stage that keeps the oldest data and drops the newest. It is the counterpart of the keep-newest "always-accept" stage: i_r is permanently high, so the producer never stalls. When the internal buffer is full, newly offered beats are discarded rather than overwriting held data. It sits at the boundaries of event and trace sources that must never be back-pressured, where the first occurrences matter more than the latest ones.

---
 rtl/base_afirst_pkg.sv | 9 +
 rtl/base_afirst_buf.sv | 80 ++++++++
 rtl/base_afirst.sv | 74 +++++++
 tb/tb_base_afirst.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/base_afirst_pkg.sv
// Shared helpers for the base_afirst keep-oldest lossy input stage.
package base_afirst_pkg;

  // Pointer width for a buffer of d entries; never narrower than one bit.
  function automatic int ptr_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/base_afirst_buf.sv
// Circular buffer for base_afirst: read/write pointers, occupancy count and storage.
module base_afirst_buf
  import base_afirst_pkg::*;
#(
  parameter int width = 1,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [0:width-1] wr_d,
  output logic [0:width-1] rd_d,
  output logic             full,
  output logic             empty
);

  localparam int ptrw = ptr_width(depth);
  localparam int occw = ptrw + 1;

  logic [ptrw-1:0]  rd_ptr_r;
  logic [ptrw-1:0]  wr_ptr_r;
  logic [occw-1:0]  count_r;
  logic [occw-1:0]  count_nxt_s;
  logic             empty_r;
  logic             full_r;
  logic [0:width-1] mem_r [depth];

  // Explicit wrap keeps depth=1 correct, where the pointer must stay at zero.
  function automatic logic [ptrw-1:0] ptr_inc(input logic [ptrw-1:0] p);
    if (p == ptrw'(depth - 1)) begin
      return {ptrw{1'b0}};
    end else begin
      return p + ptrw'(1);
    end
  endfunction

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push, pop})
      2'b10:   count_nxt_s = count_r + occw'(1);
      2'b01:   count_nxt_s = count_r - occw'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count and registered empty/full flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {ptrw{1'b0}};
      wr_ptr_r <= {ptrw{1'b0}};
      count_r  <= {occw{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == {occw{1'b0}});
      full_r  <= (count_nxt_s == occw'(depth));
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wr_d;
    end
  end

  assign rd_d  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/base_afirst.sv
// Keep-oldest lossy input stage: never back-pressures, drops new beats when full.
// Optional saturating drop counter enabled by defining BASE_AFIRST_DCNT_EN.
module base_afirst
  import base_afirst_pkg::*;
#(
  parameter int width = 1,
  parameter int depth = 2,
  parameter int cntw  = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic             i_r,
  input  logic             i_v,
  input  logic [0:width-1] i_d,
  input  logic             o_r,
  output logic             o_v,
  output logic [0:width-1] o_d,
  output logic             o_drop
`ifdef BASE_AFIRST_DCNT_EN
  ,
  input  logic             i_dclr,
  output logic [0:cntw-1]  o_dcnt
`endif
);

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic drop_s;

  // A full buffer still accepts a beat when the head leaves in the same cycle.
  assign pop_s  = ~empty_s & o_r;
  assign push_s = i_v & (~full_s | pop_s);
  assign drop_s = i_v & ~push_s;

  assign i_r    = 1'b1;
  assign o_v    = ~empty_s;
  assign o_drop = drop_s;

  base_afirst_buf #(
    .width (width),
    .depth (depth)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wr_d  (i_d),
    .rd_d  (o_d),
    .full  (full_s),
    .empty (empty_s)
  );

`ifdef BASE_AFIRST_DCNT_EN
  logic [0:cntw-1] dcnt_r;

  // Saturating drop counter; clear wins over a same-cycle drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt_r <= {cntw{1'b0}};
    end else if (i_dclr) begin
      dcnt_r <= {cntw{1'b0}};
    end else if (drop_s && !(&dcnt_r)) begin
      dcnt_r <= dcnt_r + cntw'(1);
    end else begin
      dcnt_r <= dcnt_r;
    end
  end

  assign o_dcnt = dcnt_r;
`endif

endmodule

// File: tb/tb_base_afirst.sv
// Self-checking bench for base_afirst (width=4, depth=2, cntw=2).
module tb_base_afirst;

  localparam int W = 4;
  localparam int D = 2;
  localparam int C = 2;
  localparam int CMAX = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_r;
  logic         i_v = 1'b0;
  logic [0:W-1] i_d = '0;
  logic         o_r = 1'b0;
  logic         o_v;
  logic [0:W-1] o_d;
  logic         o_drop;
  logic         dclr = 1'b0;
`ifdef BASE_AFIRST_DCNT_EN
  logic [0:C-1] o_dcnt;
`endif

  int checks = 0;
  int errors = 0;

  base_afirst #(.width(W), .depth(D), .cntw(C)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_r    (i_r),
    .i_v    (i_v),
    .i_d    (i_d),
    .o_r    (o_r),
    .o_v    (o_v),
    .o_d    (o_d),
    .o_drop (o_drop)
`ifdef BASE_AFIRST_DCNT_EN
    ,
    .i_dclr (dclr),
    .o_dcnt (o_dcnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_dcnt(input string nm, input int exp);
`ifdef BASE_AFIRST_DCNT_EN
    chk(nm, 32'(o_dcnt), 32'(exp));
`endif
  endtask

  // Drive inputs just after the falling edge, then settle before sampling.
  task automatic drive(input logic iv, input logic [3:0] d, input logic orr, input logic clr);
    @(negedge clk);
    i_v  = iv;
    i_d  = d;
    o_r  = orr;
    dclr = clr;
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [3:0] d;
    logic       orr;
    logic       ov;
    logic [3:0] od;
    logic       drop;
    int         dcnt;
  } vec_t;

  vec_t tbl[14];

  logic [3:0] q[$];
  int mcnt;
  int offered, dut_drops, dut_pops;
  logic exp_ov, exp_drop, mpop, mpush;

  initial begin
    // Directed sequence: fill, overflow, drain, then full with simultaneous push/pop.
    tbl[0]  = '{1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0, 0};
    tbl[1]  = '{1'b1, 4'hB, 1'b0, 1'b1, 4'hA, 1'b0, 0};
    tbl[2]  = '{1'b1, 4'hC, 1'b0, 1'b1, 4'hA, 1'b1, 0};
    tbl[3]  = '{1'b1, 4'hD, 1'b0, 1'b1, 4'hA, 1'b1, 1};
    tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'hA, 1'b0, 2};
    tbl[5]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'hB, 1'b0, 2};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2};
    tbl[7]  = '{1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 2};
    tbl[8]  = '{1'b1, 4'h2, 1'b0, 1'b1, 4'h1, 1'b0, 2};
    tbl[9]  = '{1'b1, 4'hE, 1'b1, 1'b1, 4'h1, 1'b0, 2};
    tbl[10] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 2};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 1'b0, 2};
    tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'hE, 1'b0, 2};
    tbl[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2};

    // Reset held, then idle after release.
    #12;
    chk("reset_i_r", 32'(i_r), 32'd1);
    chk("reset_o_v", 32'(o_v), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      chk("idle_o_v", 32'(o_v), 32'd0);
      chk("idle_o_drop", 32'(o_drop), 32'd0);
      chk("idle_i_r", 32'(i_r), 32'd1);
      chk_dcnt("idle_o_dcnt", 0);
    end

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].orr, 1'b0);
      chk($sformatf("vec%0d_o_v", i), 32'(o_v), 32'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("vec%0d_o_d", i), 32'(o_d), 32'(tbl[i].od));
      chk($sformatf("vec%0d_o_drop", i), 32'(o_drop), 32'(tbl[i].drop));
      chk_dcnt($sformatf("vec%0d_o_dcnt", i), tbl[i].dcnt);
    end

    // Counter clear, then saturation with held data left untouched.
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    chk_dcnt("clr_before", 2);
    drive(1'b1, 4'h1, 1'b0, 1'b0);
    chk_dcnt("clr_after", 0);
    drive(1'b1, 4'h2, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 4'h3, 1'b0, 1'b0);
      chk($sformatf("sat%0d_o_drop", k), 32'(o_drop), 32'd1);
      chk_dcnt($sformatf("sat%0d_o_dcnt", k), (k - 1 > CMAX) ? CMAX : k - 1);
    end
    drive(1'b1, 4'h3, 1'b0, 1'b1);
    chk("sat6_o_drop", 32'(o_drop), 32'd1);
    chk_dcnt("sat6_o_dcnt", CMAX);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk_dcnt("sat6_cleared", 0);
    chk("sat_head", 32'(o_d), 32'h1);
    chk("sat_o_v", 32'(o_v), 32'd1);

    // Asynchronous reset with a full buffer.
    #2;
    reset = 1'b0;
    #1;
    chk("areset_o_v", 32'(o_v), 32'd0);
    chk("areset_i_r", 32'(i_r), 32'd1);
    chk_dcnt("areset_o_dcnt", 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 4'h5, 1'b0, 1'b0);
    chk("post_rst_empty", 32'(o_v), 32'd0);
    chk("post_rst_drop", 32'(o_drop), 32'd0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    chk("post_rst_o_v", 32'(o_v), 32'd1);
    chk("post_rst_o_d", 32'(o_d), 32'h5);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("post_rst_alone", 32'(o_v), 32'd0);

    // Random traffic against a queue model.
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    q.delete();
    mcnt = 0;
    offered = 0;
    dut_drops = 0;
    dut_pops = 0;
    for (int n = 0; n < 10000; n++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 4'($urandom),
            ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
            ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
      exp_ov   = (q.size() != 0);
      exp_drop = i_v && (q.size() == D) && !o_r;
      chk("rnd_o_v", 32'(o_v), 32'(exp_ov));
      if (exp_ov) chk("rnd_o_d", 32'(o_d), 32'(q[0]));
      chk("rnd_o_drop", 32'(o_drop), 32'(exp_drop));
      chk_dcnt("rnd_o_dcnt", mcnt);
      if (i_v) offered++;
      if (o_drop) dut_drops++;
      if (o_v && o_r) dut_pops++;
      mpop  = exp_ov && o_r;
      mpush = i_v && ((q.size() < D) || mpop);
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(i_d);
      if (dclr) mcnt = 0;
      else if (exp_drop && mcnt < CMAX) mcnt++;
    end
    chk("balance", 32'(offered), 32'(dut_drops + dut_pops + q.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
